mux4bit_rr_arbiter: RTL and testbench

- Two-requester round-robin arbiter that owns a shared 4-bit 2:1 select path and drives a single registered output bus.
- Each requester presents req plus data and receives a one-hot grant.
- Grant is held while the owner keeps req high, bounded by MAX_HOLD when the other side is waiting.
- Sits in front of any consumer that accepts one 4-bit word per cycle from either source.

---
 rtl/mux4bit_arb_pkg.sv | 19 +
 rtl/mux4bit_2to1_reg.sv | 36 +++
 rtl/mux4bit_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_mux4bit_rr_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux4bit_arb_pkg.sv
// Shared definitions for the two-requester round-robin arbiter and its output select register.
package mux4bit_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } arb_state_e;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   localparam int DEF_WIDTH    = 4;
   localparam int DEF_MAX_HOLD = 4;

   // Hold counter only needs to reach MAX_HOLD-1, and MAX_HOLD is at most 15.
   localparam int HOLD_W = 4;

endpackage

// File: rtl/mux4bit_2to1_reg.sv
// Registered WIDTH-bit 2:1 select; loads the selected input when load is high, otherwise holds.
module mux4bit_2to1_reg
   import mux4bit_arb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic             load,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = (sel == SRC_B) ? b : a;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/mux4bit_rr_arbiter.sv
// Two-requester round-robin arbiter driving a registered 4-bit output bus.
// Optional per-source transfer counters are enabled with `define ARB_GRANT_CNT_EN.
module mux4bit_rr_arbiter
   import mux4bit_arb_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef ARB_GRANT_CNT_EN
   input  logic             cnt_clr,
   output logic [7:0]       cnt_a,
   output logic [7:0]       cnt_b,
`endif
   output logic             gnt_a,
   output logic             gnt_b,
   output logic [WIDTH-1:0] c,
   output logic             c_vld,
   output logic             c_src
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   arb_state_e        state_d, state_q;
   logic [HOLD_W-1:0] hold_cnt_d, hold_cnt_q;
   logic              last_d, last_q;
   logic              c_vld_d, c_vld_q;
   logic              c_src_d, c_src_q;
   logic              xfer;
   logic              sel;

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      last_d     = last_q;
      unique case (state_q)
         IDLE: begin
            if (req_a && req_b) begin
               state_d = (last_q == SRC_B) ? OWN_A : OWN_B;
            end else if (req_a) begin
               state_d = OWN_A;
            end else if (req_b) begin
               state_d = OWN_B;
            end
         end
         OWN_A: begin
            if (!req_a) begin
               state_d = req_b ? OWN_B : IDLE;
            end else if (req_b && (hold_cnt_q == HOLD_LAST)) begin
               state_d = OWN_B;
            end
         end
         OWN_B: begin
            if (!req_b) begin
               state_d = req_a ? OWN_A : IDLE;
            end else if (req_a && (hold_cnt_q == HOLD_LAST)) begin
               state_d = OWN_A;
            end
         end
         default: state_d = IDLE;
      endcase

      // Counter restarts on any ownership change and parks at HOLD_LAST while uncontested.
      if (state_d != state_q) begin
         hold_cnt_d = '0;
         if (state_d == OWN_A) begin
            last_d = SRC_A;
         end else if (state_d == OWN_B) begin
            last_d = SRC_B;
         end
      end else if ((state_q != IDLE) && (hold_cnt_q != HOLD_LAST)) begin
         hold_cnt_d = hold_cnt_q + 1'b1;
      end
   end

   assign xfer = ((state_q == OWN_A) && req_a) || ((state_q == OWN_B) && req_b);
   assign sel  = (state_q == OWN_B) ? SRC_B : SRC_A;

   always_comb begin
      c_vld_d = xfer;
      c_src_d = xfer ? sel : c_src_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         last_q     <= SRC_B;
         c_vld_q    <= 1'b0;
         c_src_q    <= SRC_A;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         last_q     <= last_d;
         c_vld_q    <= c_vld_d;
         c_src_q    <= c_src_d;
      end
   end

   mux4bit_2to1_reg #(
      .WIDTH(WIDTH)
   ) u_out_reg (
      .clk (clk),
      .rst (rst),
      .sel (sel),
      .load(xfer),
      .a   (a),
      .b   (b),
      .q   (c)
   );

   assign gnt_a = (state_q == OWN_A);
   assign gnt_b = (state_q == OWN_B);
   assign c_vld = c_vld_q;
   assign c_src = c_src_q;

`ifdef ARB_GRANT_CNT_EN
   logic [7:0] cnt_a_d, cnt_a_q;
   logic [7:0] cnt_b_d, cnt_b_q;

   // Clear wins over a same-cycle increment; counters wrap naturally at 8 bits.
   always_comb begin
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      if (cnt_clr) begin
         cnt_a_d = '0;
         cnt_b_d = '0;
      end else if (xfer) begin
         if (sel == SRC_A) begin
            cnt_a_d = cnt_a_q + 8'd1;
         end else begin
            cnt_b_d = cnt_b_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
      end
   end

   assign cnt_a = cnt_a_q;
   assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_mux4bit_rr_arbiter.sv
// Self-checking bench: ownership/run-length reference model plus scripted literal scenarios.
module tb_mux4bit_rr_arbiter;

   localparam int WIDTH    = 4;
   localparam int MAX_HOLD = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_a, req_b;
   logic [WIDTH-1:0] a, b;
   logic             gnt_a, gnt_b;
   logic [WIDTH-1:0] c;
   logic             c_vld, c_src;
`ifdef ARB_GRANT_CNT_EN
   logic             cnt_clr;
   logic [7:0]       cnt_a, cnt_b;
`endif

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mux4bit_rr_arbiter #(
      .WIDTH   (WIDTH),
      .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req_a  (req_a),
      .req_b  (req_b),
      .a      (a),
      .b      (b),
`ifdef ARB_GRANT_CNT_EN
      .cnt_clr(cnt_clr),
      .cnt_a  (cnt_a),
      .cnt_b  (cnt_b),
`endif
      .gnt_a  (gnt_a),
      .gnt_b  (gnt_b),
      .c      (c),
      .c_vld  (c_vld),
      .c_src  (c_src)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: owner 0=none, 1=A, 2=B; run = granted cycles so far in the current ownership.
   int         m_own, m_last, m_run;
   logic [3:0] exp_c;
   logic       exp_vld, exp_src;
   int         exp_cnt_a, exp_cnt_b;

   function automatic int next_owner(int own, int last, int run, logic ra, logic rb);
      logic mine, oth;
      if (own == 0) begin
         if (ra && rb) return (last == 1) ? 2 : 1;
         if (ra) return 1;
         if (rb) return 2;
         return 0;
      end
      mine = (own == 1) ? ra : rb;
      oth  = (own == 1) ? rb : ra;
      if (!mine) return oth ? 3 - own : 0;
      if (oth && run >= MAX_HOLD) return 3 - own;
      return own;
   endfunction

   int   nxt;
   logic m_xfer;
   logic clr_in;
   assign nxt    = next_owner(m_own, m_last, m_run, req_a, req_b);
   assign m_xfer = (m_own == 1 && req_a) || (m_own == 2 && req_b);
`ifdef ARB_GRANT_CNT_EN
   assign clr_in = cnt_clr;
`else
   assign clr_in = 1'b0;
`endif

   always @(posedge clk) begin
      if (rst) begin
         m_own     <= 0;
         m_last    <= 2;
         m_run     <= 0;
         exp_c     <= '0;
         exp_vld   <= 1'b0;
         exp_src   <= 1'b0;
         exp_cnt_a <= 0;
         exp_cnt_b <= 0;
      end else begin
         m_own <= nxt;
         if (nxt != m_own) begin
            m_run <= (nxt != 0) ? 1 : 0;
            if (nxt != 0) m_last <= nxt;
         end else if (nxt != 0) begin
            m_run <= m_run + 1;
         end
         exp_vld <= m_xfer;
         if (m_xfer) begin
            exp_c   <= (m_own == 1) ? a : b;
            exp_src <= (m_own == 2);
         end
         if (clr_in) begin
            exp_cnt_a <= 0;
            exp_cnt_b <= 0;
         end else if (m_xfer) begin
            if (m_own == 1) exp_cnt_a <= (exp_cnt_a + 1) % 256;
            else            exp_cnt_b <= (exp_cnt_b + 1) % 256;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("gnt_a", gnt_a, m_own == 1);
         check("gnt_b", gnt_b, m_own == 2);
         check("c", c, exp_c);
         check("c_vld", c_vld, exp_vld);
         check("c_src", c_src, exp_src);
`ifdef ARB_GRANT_CNT_EN
         check("cnt_a", cnt_a, exp_cnt_a);
         check("cnt_b", cnt_b, exp_cnt_b);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [11:0] pat;
      rst = 1'b1; req_a = 1'b1; req_b = 1'b1; a = 4'h5; b = 4'hA;
`ifdef ARB_GRANT_CNT_EN
      cnt_clr = 1'b0;
`endif
      tick();
      chk_en = 1'b1;
      tick();
      check("rst_gnt_a", gnt_a, 1'b0);
      check("rst_gnt_b", gnt_b, 1'b0);
      check("rst_c", c, 4'h0);
      check("rst_c_vld", c_vld, 1'b0);
      rst = 1'b0;

      // Constant contention: runs of MAX_HOLD grants, data one cycle behind.
      pat = 12'b1111_0000_1111;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("cont_gnt_a", gnt_a, pat[11-i]);
         check("cont_gnt_b", gnt_b, !pat[11-i]);
         if (i > 0) begin
            check("cont_c", c, pat[12-i] ? 4'h5 : 4'hA);
            check("cont_src", c_src, !pat[12-i]);
         end
      end

      // Release handoff: A alone for a while, then A drops as B asks.
      req_b = 1'b0;
      repeat (3) tick();
      check("solo_gnt_a", gnt_a, 1'b1);
      req_a = 1'b0; req_b = 1'b1; b = 4'hF;
      tick();
      check("hand_gnt_b", gnt_b, 1'b1);
      check("hand_gnt_a", gnt_a, 1'b0);
      check("hand_vld", c_vld, 1'b0);
      tick();
      check("hand_c", c, 4'hF);
      check("hand_src", c_src, 1'b1);
      check("hand_vld2", c_vld, 1'b1);

      // Mid-burst reset while B owns.
      rst = 1'b1; req_a = 1'b1;
      tick();
      check("mid_rst_gnt_b", gnt_b, 1'b0);
      check("mid_rst_vld", c_vld, 1'b0);
      rst = 1'b0;
      tick();
      check("post_rst_gnt_a", gnt_a, 1'b1);

      // Single requester: req_a held for four sampled edges.
      rst = 1'b1; tick();
      rst = 1'b0; req_a = 1'b1; req_b = 1'b0; a = 4'h3;
      tick();
      check("single_gnt", gnt_a, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("single_c", c, 4'h3);
         check("single_vld", c_vld, 1'b1);
         check("single_src", c_src, 1'b0);
      end
      req_a = 1'b0;
      tick();
      tick();
      check("single_idle_gnt", gnt_a, 1'b0);
      check("single_idle_vld", c_vld, 1'b0);

`ifdef ARB_GRANT_CNT_EN
      rst = 1'b1; tick();
      rst = 1'b0; req_a = 1'b1; req_b = 1'b0;
      repeat (301) tick();
      check("cnt_a_wrap", cnt_a, 8'd44);
      check("cnt_b_zero", cnt_b, 8'd0);
      cnt_clr = 1'b1;
      tick();
      check("cnt_clr", cnt_a, 8'd0);
      cnt_clr = 1'b0;
`endif

      // Randomized phase with sticky requests and occasional reset.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(3) == 0) req_a = ~req_a;
         if ($urandom_range(3) == 0) req_b = ~req_b;
         a   = 4'($urandom);
         b   = 4'($urandom);
         rst = ($urandom_range(99) == 0);
`ifdef ARB_GRANT_CNT_EN
         cnt_clr = ($urandom_range(63) == 0);
`endif
         tick();
      end
      rst = 1'b0;
      tick();
      chk_en = 1'b0;
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
